// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared single-precision compare types and field positions
package fpu_pkg;

    typedef enum logic [1:0] {
        FCMP_EQ  = 2'b00,
        FCMP_LT  = 2'b01,
        FCMP_LE  = 2'b10,
        FCMP_RSV = 2'b11
    } fcmp_op_t;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;
    localparam int MANT_LSB = 0;

    localparam logic [7:0] EXP_MAX = 8'hFF;

endpackage

// File: rtl/fcmp_core.sv
// rtl/fcmp_core.sv - combinational IEEE-754 single compare (FEQ/FLT/FLE)
import fpu_pkg::*;

module fcmp_core (
    input  fcmp_op_t    op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        cmp
);

    logic        x_sign, y_sign;
    logic [30:0] x_mag, y_mag;
    logic        x_nan, y_nan, any_nan;
    logic        both_zero;
    logic        eq, lt;

    assign x_sign = x[SIGN_BIT];
    assign y_sign = y[SIGN_BIT];
    assign x_mag  = x[EXP_MSB:MANT_LSB];
    assign y_mag  = y[EXP_MSB:MANT_LSB];

    assign x_nan   = (x[EXP_MSB:EXP_LSB] == EXP_MAX) && (x[MANT_MSB:MANT_LSB] != '0);
    assign y_nan   = (y[EXP_MSB:EXP_LSB] == EXP_MAX) && (y[MANT_MSB:MANT_LSB] != '0);
    assign any_nan = x_nan | y_nan;

    // +0 and -0 differ only in the sign bit but must compare equal
    assign both_zero = (x_mag == '0) && (y_mag == '0);

    assign eq = ~any_nan & ((x == y) | both_zero);

    always_comb begin
        lt = 1'b0;
        if (x_sign != y_sign) begin
            lt = x_sign & ~both_zero;
        end else if (x_sign) begin
            lt = x_mag > y_mag;
        end else begin
            lt = x_mag < y_mag;
        end
        lt = lt & ~any_nan;
    end

    always_comb begin
        cmp = 1'b0;
        case (op)
            FCMP_EQ: cmp = eq;
            FCMP_LT: cmp = lt;
            FCMP_LE: cmp = lt | eq;
            default: cmp = 1'b0;
        endcase
    end

endmodule

// File: rtl/fcmp_sched.sv
// rtl/fcmp_sched.sv - round-robin shared compare unit with 2-stage tagged pipeline
import fpu_pkg::*;

module fcmp_sched #(
    parameter int NREQ = 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_x,
    input  logic [32*NREQ-1:0]   req_y,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_data
);

    logic           s1_v, s2_v;
    fcmp_op_t       s1_op;
    logic [31:0]    s1_x, s1_y;
    logic [IDW-1:0] s1_id;
    logic [IDW-1:0] s2_id;
    logic [31:0]    s2_data;
    logic [IDW-1:0] rr_ptr;

    logic           s2_ready, s1_ready;
    logic           found, accept;
    logic [IDW-1:0] grant;
    int             grant_idx;
    int             idx;
    logic           cmp;

    assign s2_ready = ~s2_v | resp_ready;
    assign s1_ready = ~s1_v | s2_ready;

    always_comb begin
        found     = 1'b0;
        grant_idx = 0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign grant  = IDW'(grant_idx);
    // rst gating keeps req_ready low while reset is asserted
    assign accept = found & s1_ready & ~flush & ~rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    fcmp_core u_core (
        .op  (s1_op),
        .x   (s1_x),
        .y   (s1_y),
        .cmp (cmp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            rr_ptr  <= '0;
            s1_op   <= FCMP_EQ;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_id   <= '0;
            s2_id   <= '0;
            s2_data <= '0;
        end else if (flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s2_ready) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_id   <= s1_id;
                    s2_data <= {31'b0, cmp};
                end
            end
            if (accept) begin
                s1_v   <= 1'b1;
                s1_op  <= fcmp_op_t'(req_op[2*grant_idx +: 2]);
                s1_x   <= req_x[32*grant_idx +: 32];
                s1_y   <= req_y[32*grant_idx +: 32];
                s1_id  <= grant;
                rr_ptr <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
            end else if (s2_ready) begin
                s1_v <= 1'b0;
            end
        end
    end

    assign resp_valid = s2_v;
    assign resp_id    = s2_id;
    assign resp_data  = s2_data;

endmodule

// File: tb/tb_fcmp_sched.sv
// tb/tb_fcmp_sched.sv - self-checking bench for fcmp_sched
module tb_fcmp_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_x;
    logic [63:0] req_y;
    logic        resp_valid;
    logic        resp_ready;
    logic [0:0]  resp_id;
    logic [31:0] resp_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fcmp_sched #(.NREQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
    );

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic        exp;
    } vec_t;

    typedef struct {
        int   id;
        logic data;
        int   t;
    } exp_t;

    exp_t q[$];
    int   rr_m = 0;
    int   cyc  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Order-preserving integer key: negative floats map below positive, both zeros to 0
    function automatic longint fkey(input logic [31:0] v);
        longint mag;
        mag = longint'(v[30:0]);
        return v[31] ? -mag : mag;
    endfunction

    function automatic bit is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 0);
    endfunction

    function automatic logic ref_cmp(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        if (is_nan(x) || is_nan(y)) return 1'b0;
        case (op)
            2'b00:   return fkey(x) == fkey(y);
            2'b01:   return fkey(x) <  fkey(y);
            2'b10:   return fkey(x) <= fkey(y);
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_req(input int i, input logic v, input logic [1:0] op,
                           input logic [31:0] x, input logic [31:0] y);
        req_valid[i]       = v;
        req_op[2*i +: 2]   = op;
        req_x[32*i +: 32]  = x;
        req_y[32*i +: 32]  = y;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        logic [1:0] oh;
        @(negedge clk);
        req_valid  = '0;
        resp_ready = 1'b1;
        set_req(v.id, 1'b1, v.op, v.x, v.y);
        oh = '0;
        oh[v.id] = 1'b1;
        #1 chk($sformatf("vec%0d_req_ready", n), 64'(req_ready), 64'(oh));
        @(negedge clk);
        req_valid = '0;
        #1 chk($sformatf("vec%0d_latency1", n), 64'(resp_valid), 64'd0);
        @(negedge clk);
        #1;
        chk($sformatf("vec%0d_valid", n), 64'(resp_valid), 64'd1);
        chk($sformatf("vec%0d_id", n), 64'(resp_id), 64'(v.id));
        chk($sformatf("vec%0d_data", n), 64'(resp_data), 64'(v.exp));
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] pool [8];
        pool[0] = 32'h3F800000; pool[1] = 32'h40000000; pool[2] = 32'hBF800000;
        pool[3] = 32'h00000000; pool[4] = 32'h80000000; pool[5] = 32'h7FC00000;
        pool[6] = 32'h7F800000; pool[7] = 32'h00000001;
        if ($urandom_range(0, 3) == 0) return $urandom;
        return pool[$urandom_range(0, 7)];
    endfunction

    task automatic cycle_step(input bit rnd);
        logic [1:0] expr;
        logic       s1r, expv;
        int         g, idx;
        @(negedge clk);
        if (rnd) begin
            for (int i = 0; i < 2; i++)
                set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), pick_val(), pick_val());
            resp_ready = 1'($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 19) == 0);
        end else begin
            req_valid  = '0;
            resp_ready = 1'b1;
            flush      = 1'b0;
        end
        #1;
        s1r = (q.size() < 2) || resp_ready;
        g = -1;
        for (int k = 0; k < 2; k++) begin
            idx = (rr_m + k) % 2;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        expr = '0;
        if (g >= 0 && s1r && !flush) expr[g] = 1'b1;
        chk("rand_req_ready", 64'(req_ready), 64'(expr));
        expv = (q.size() > 0) && (cyc - q[0].t >= 2);
        chk("rand_resp_valid", 64'(resp_valid), 64'(expv));
        if (expv && !flush) begin
            chk("rand_resp_id", 64'(resp_id), 64'(q[0].id));
            chk("rand_resp_data", 64'(resp_data), 64'(q[0].data));
        end
        if (flush) begin
            q.delete();
        end else begin
            if (expv && resp_ready) void'(q.pop_front());
            if (expr != 0) begin
                q.push_back('{id: g, data: ref_cmp(req_op[2*g +: 2], req_x[32*g +: 32], req_y[32*g +: 32]), t: cyc});
                rr_m = (g + 1) % 2;
            end
        end
        cyc++;
    endtask

    initial begin
        vec_t vecs [14];
        logic [1:0] oh;
        int acc;

        vecs[0]  = '{0, 2'b10, 32'h3F800000, 32'h40000000, 1'b1};
        vecs[1]  = '{0, 2'b01, 32'h3F800000, 32'h40000000, 1'b1};
        vecs[2]  = '{0, 2'b00, 32'h3F800000, 32'h40000000, 1'b0};
        vecs[3]  = '{1, 2'b00, 32'h80000000, 32'h00000000, 1'b1};
        vecs[4]  = '{1, 2'b01, 32'h80000000, 32'h00000000, 1'b0};
        vecs[5]  = '{0, 2'b10, 32'h7FC00000, 32'h3F800000, 1'b0};
        vecs[6]  = '{1, 2'b00, 32'h7FC00000, 32'h7FC00000, 1'b0};
        vecs[7]  = '{0, 2'b01, 32'hC0000000, 32'hBF800000, 1'b1};
        vecs[8]  = '{1, 2'b01, 32'hBF800000, 32'hC0000000, 1'b0};
        vecs[9]  = '{0, 2'b11, 32'h3F800000, 32'h40000000, 1'b0};
        vecs[10] = '{1, 2'b10, 32'h00000001, 32'h00000002, 1'b1};
        vecs[11] = '{0, 2'b10, 32'h40000000, 32'h40000000, 1'b1};
        vecs[12] = '{1, 2'b01, 32'hFF800000, 32'h7F800000, 1'b1};
        vecs[13] = '{0, 2'b01, 32'h00000000, 32'h80000000, 1'b0};

        rst = 1'b1; flush = 1'b0; resp_ready = 1'b1;
        req_valid = 2'b11; req_op = '0; req_x = '0; req_y = '0;
        #2;
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_resp_id", 64'(resp_id), 64'd0);
        chk("reset_resp_data", 64'(resp_data), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Async reset in the middle of a stream, then fairness from a clean pointer
        @(negedge clk);
        set_req(0, 1'b1, 2'b01, 32'h3F800000, 32'h40000000);
        set_req(1, 1'b1, 2'b01, 32'h3F800000, 32'h40000000);
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("midstream_valid_before_rst", 64'(resp_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("async_rst_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("fair_req_ready%0d", k), 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k >= 2) begin
                chk($sformatf("fair_resp_valid%0d", k), 64'(resp_valid), 64'd1);
                chk($sformatf("fair_resp_id%0d", k), 64'(resp_id), 64'((k - 2) % 2));
                chk($sformatf("fair_resp_data%0d", k), 64'(resp_data), 64'd1);
            end
        end

        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);

        // Backpressure: two accepts fill the pipe, then everything stalls
        set_req(0, 1'b1, 2'b00, 32'h3F800000, 32'h3F800000);
        set_req(1, 1'b1, 2'b01, 32'h40000000, 32'h3F800000);
        resp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            acc += int'(req_ready[0]) + int'(req_ready[1]);
            if (k >= 2) begin
                chk($sformatf("bp_req_ready%0d", k), 64'(req_ready), 64'd0);
                chk($sformatf("bp_valid%0d", k), 64'(resp_valid), 64'd1);
                chk($sformatf("bp_id%0d", k), 64'(resp_id), 64'd0);
                chk($sformatf("bp_data%0d", k), 64'(resp_data), 64'd1);
            end
        end
        chk("bp_accept_count", 64'(acc), 64'd2);
        @(negedge clk);
        req_valid = '0;
        resp_ready = 1'b1;
        #1;
        chk("drain0_valid", 64'(resp_valid), 64'd1);
        chk("drain0_id", 64'(resp_id), 64'd0);
        chk("drain0_data", 64'(resp_data), 64'd1);
        @(negedge clk);
        #1;
        chk("drain1_valid", 64'(resp_valid), 64'd1);
        chk("drain1_id", 64'(resp_id), 64'd1);
        chk("drain1_data", 64'(resp_data), 64'd0);
        @(negedge clk);
        #1 chk("drain2_valid", 64'(resp_valid), 64'd0);

        // Flush with both stages full
        set_req(0, 1'b1, 2'b00, 32'h3F800000, 32'h3F800000);
        set_req(1, 1'b1, 2'b00, 32'h3F800000, 32'h3F800000);
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        resp_ready = 1'b1;
        #1 chk("flush_no_accept", 64'(req_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        req_valid = '0;
        #1 chk("flush_resp_valid0", 64'(resp_valid), 64'd0);
        @(negedge clk);
        #1 chk("flush_resp_valid1", 64'(resp_valid), 64'd0);
        req_valid = 2'b11;
        oh = 2'b01;
        #1 chk("flush_rr_unchanged", 64'(req_ready), 64'(oh));
        req_valid = '0;

        rr_m = 0;
        q.delete();
        for (int n = 0; n < 400; n++) cycle_step(1'b1);
        for (int n = 0; n < 6; n++) cycle_step(1'b0);
        chk("rand_all_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fcmp_sched.md
Name: fcmp_sched

Overview:
- Shares one single-precision compare datapath (FEQ/FLT/FLE) among NREQ requesters, e.g. the integer pipe and the FPU issue slot.
- Round-robin arbiter feeds a 2-stage pipeline: operand register, then result register.
- Single tagged response channel with valid/ready backpressure; flush input for pipeline redirect.
- Result format matches the existing compare units: {31'b0, bit}.

Parameters:
- NREQ, 2, number of requesters (≥1).
- IDW (localparam), max(1,$clog2(NREQ)), requester-id width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all in-flight ops.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_op  in  2*NREQ  per-requester op: 00 FEQ, 01 FLT, 10 FLE, 11 reserved.
- req_x  in  32*NREQ  operand x, IEEE-754 single.
- req_y  in  32*NREQ  operand y.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  index of the requester that issued the op.
- resp_data  out  32  {31'b0, cmp}.

Behaviour:
- Reset (async, rst=1): s1_v=0, s2_v=0, rr_ptr=0.
  - Outputs during reset: resp_valid=0, resp_id=0, resp_data=0, req_ready=0.
  - Reset mid-operation drops all in-flight ops without producing a response.
- Pipeline control:
  - s2_ready = ~s2_v | resp_ready.
  - s1_ready = ~s1_v | s2_ready.
- Arbitration:
  - grant = first i with req_valid[i], searching from rr_ptr upward with wrap.
  - req_ready[i] = (i==grant) & any(req_valid) & s1_ready & ~flush.
  - req_ready depends combinationally on req_valid; requesters must not make valid depend on ready.
- Accept (req_valid[i] & req_ready[i] at an edge):
  - S1 <= {op, x, y, id=i}, s1_v <= 1.
  - rr_ptr <= (i+1) mod NREQ.
  - rr_ptr is unchanged when nothing is accepted.
- Stage advance:
  - S1→S2 when s1_v & s2_ready.
  - S2 <= {cmp result from fcmp_core, id}.
  - s1_v clears unless a new accept occurs in the same cycle.
- Response: S2 drives resp_valid/resp_id/resp_data directly from registers, with no combinational path from inputs.
  - Held stable while resp_valid & ~resp_ready.
  - Pops on resp_valid & resp_ready.
- Latency and throughput:
  - Accept at edge N → resp_valid high in the cycle after edge N+1 (2 cycles), assuming resp_ready=1.
  - Throughput 1 op/cycle.
- Full condition: s1_v & s2_v & ~resp_ready → req_ready all 0, no state changes.
- Simultaneous pop and push:
  - S2 pops and S1 advances into it in the same edge.
  - S1 may accept a new op in that same edge.
- Flush (sampled at edge):
  - s1_v <= 0, s2_v <= 0; no accept that cycle; rr_ptr unchanged.
  - Flush overrides a same-cycle handshake on resp; the consumer must ignore resp in a flush cycle.
- Compare semantics (fcmp_core):
  - Any NaN operand (exp=0xFF, mant≠0) → 0 for all ops.
  - +0 and -0 compare equal.
  - Otherwise standard sign-magnitude ordering.
  - FLE = FLT | FEQ.
  - Op 11 → 0.
  - Denormals are compared as encoded (no flush-to-zero).

Decomposition:
- Package fpu_pkg holds:
  - typedef enum logic [1:0] fcmp_op_t {FCMP_EQ, FCMP_LT, FCMP_LE, FCMP_RSV}.
  - localparams for the float field positions (sign 31, exp 30:23, mant 22:0).
  - Constant EXP_MAX = 8'hFF.
- Sub-module fcmp_core:
  - Purely combinational: (op, x, y) → cmp.
  - Instantiated once between S1 and S2.
  - Unit-tested standalone.

Test Plan:
- Basic ops:
  - Requester 0, FLE, x=0x3F800000 (1.0), y=0x40000000 (2.0) → after 2 cycles resp_valid=1, resp_id=0, resp_data=1.
  - Same operands with FLT → 1; FEQ → 0.
- Signed zero and NaN:
  - FEQ x=0x80000000, y=0x00000000 → 1.
  - FLT same operands → 0.
  - FLE x=0x7FC00000 (NaN), y=0x3F800000 → 0.
  - FEQ NaN,NaN → 0.
- Negatives: FLT x=0xC0000000 (-2.0), y=0xBF800000 (-1.0) → 1; swapped operands → 0.
- Fairness:
  - Both requesters valid continuously, resp_ready=1 → req_ready alternates 0,1,0,1 starting at requester 0.
  - resp_id sequence is 0,1,0,1 with one response per cycle.
- Backpressure:
  - resp_ready=0 for 4 cycles with continuous requests → exactly 2 accepts, then req_ready=0.
  - resp_valid/resp_id/resp_data stay stable throughout.
  - On release, responses drain in order with no loss or duplication.
- Flush and reset:
  - flush=1 with both stages full → next cycle resp_valid=0; no accept in the flush cycle.
  - Asserting rst asynchronously mid-stream forces resp_valid=0 immediately.
  - After release, the first grant goes to requester 0.
